// File: rtl/data_memory_bytelane.sv
// rtl/data_memory_bytelane.sv - byte-addressable little-endian data memory with registered loads
module data_memory_bytelane #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DEPTH          = 256,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic [ADDR_WIDTH-1:0] i_Addr,
   input  logic [31:0]           i_WriteData,
   input  logic                  i_MemWrite,
   input  logic                  i_MemRead,
   input  logic [1:0]            i_MemSize,
   input  logic                  i_MemSigned,
   output logic [31:0]           o_DataRead,
   output logic                  o_ReadValid,
   output logic                  o_Fault,
   output logic                  o_InitBusy
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [IDX_W-1:0] r_cnt;
   logic [IDX_W-1:0] w_cnt_next;
   logic [31:0]      r_mem [DEPTH];

   logic             w_req;
   logic             w_in_range;
   logic             w_misalign;
   logic             w_accept;
   logic [1:0]       w_lane;
   logic [IDX_W-1:0] w_idx;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [31:0]      w_rd_word;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [31:0]      w_load;

   // Init state and sweep counter; reset restarts the sweep from word 0
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         if (CLEAR_ON_RESET) r_state <= ST_INIT;
         else                r_state <= ST_READY;
         r_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Sweep advances one word per cycle and hands over after the last word
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         ST_INIT: begin
            w_cnt_next = r_cnt + IDX_W'(1);
            if (r_cnt == IDX_W'(DEPTH - 1)) begin
               w_state_next = ST_READY;
               w_cnt_next   = '0;
            end
         end
         default: ;
      endcase
   end

   assign o_InitBusy = (r_state == ST_INIT);

   assign w_req      = i_MemRead | i_MemWrite;
   assign w_lane     = i_Addr[1:0];
   assign w_idx      = i_Addr[IDX_W+1:2];
   assign w_in_range = ((i_Addr >> (IDX_W + 2)) == '0);
   assign w_rd_word  = r_mem[w_idx];

   // Legality check; one verdict covers both halves of a read+write cycle
   always_comb begin
      w_misalign = 1'b0;
      case (i_MemSize)
         2'b00:   w_misalign = 1'b0;
         2'b01:   w_misalign = w_lane[0];
         2'b10:   w_misalign = (w_lane != 2'b00);
         default: w_misalign = 1'b1;
      endcase
      w_accept = w_req & w_in_range & ~w_misalign & (r_state == ST_READY);
   end

   // Lane enables and right-aligned store data replicated onto every lane
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = i_WriteData;
      case (i_MemSize)
         2'b00: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{i_WriteData[7:0]}};
         end
         2'b01: begin
            w_be    = i_Addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_WriteData[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = i_WriteData;
         end
      endcase
   end

   // Load extraction and sign/zero extension; word loads ignore MemSigned
   always_comb begin
      w_byte = w_rd_word[{w_lane, 3'b000} +: 8];
      w_half = i_Addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
      case (i_MemSize)
         2'b00:   w_load = {{24{i_MemSigned & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{i_MemSigned & w_half[15]}}, w_half};
         default: w_load = w_rd_word;
      endcase
   end

   // Storage: zeroing sweep during init, lane-masked stores when ready
   always_ff @(posedge i_Clk) begin
      if (!i_Rst) begin
         if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= '0;
         end else if (w_accept && i_MemWrite) begin
            for (int l = 0; l < 4; l++) begin
               if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
            end
         end
      end
   end

   // Registered load result, valid strobe and fault pulse
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_DataRead  <= '0;
         o_ReadValid <= 1'b0;
         o_Fault     <= 1'b0;
      end else begin
         o_Fault     <= w_req & ~w_accept;
         o_ReadValid <= w_accept & i_MemRead;
         if (w_accept && i_MemRead) o_DataRead <= w_load;
      end
   end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// tb/tb_data_memory_bytelane.sv - randomized self-checking bench for data_memory_bytelane
module tb_data_memory_bytelane;

   localparam int D     = 256;
   localparam int BYTES = 4 * D;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wd;
   logic        mw, mr, sg;
   logic [1:0]  sz;
   logic [31:0] dr;
   logic        rv, flt, busy;

   always #5 clk = ~clk;

   data_memory_bytelane #(.ADDR_WIDTH(32), .DEPTH(D), .CLEAR_ON_RESET(1'b1)) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Addr(addr), .i_WriteData(wd),
      .i_MemWrite(mw), .i_MemRead(mr), .i_MemSize(sz), .i_MemSigned(sg),
      .o_DataRead(dr), .o_ReadValid(rv), .o_Fault(flt), .o_InitBusy(busy)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]  ref_mem [0:BYTES-1];
   logic        ref_ready;
   logic [31:0] ref_dr;
   logic [31:0] obs_dr;
   logic        obs_rv, obs_flt, obs_busy;
   logic        e_rv, e_flt;

   // Reference: a flat byte array, accesses computed with plain arithmetic
   task automatic model(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [1:0] s, input logic sgn, input logic [31:0] wdat,
                        output logic x_rv, output logic x_flt);
      int n;
      logic [31:0] v;
      logic legal;
      n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
      legal = ref_ready && (a < BYTES) && (s != 2'd3) && ((a % n) == 0);
      x_rv = 1'b0;
      x_flt = 1'b0;
      if (rd || wr) begin
         if (!legal) begin
            x_flt = 1'b1;
         end else begin
            if (rd) begin
               v = 32'd0;
               for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
               if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
               ref_dr = v;
               x_rv = 1'b1;
            end
            if (wr) begin
               for (int i = 0; i < n; i++) ref_mem[a + i] = wdat[8*i +: 8];
            end
         end
      end
   endtask

   task automatic clear_ref();
      for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
      ref_dr = 32'd0;
   endtask

   // One bus cycle: drive after negedge, sample 1ns after the posedge
   task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [1:0] s, input logic sgn, input logic [31:0] wdat);
      model(rd, wr, a, s, sgn, wdat, e_rv, e_flt);
      @(negedge clk);
      mr = rd; mw = wr; addr = a; sz = s; sg = sgn; wd = wdat;
      @(posedge clk);
      #1;
      obs_dr = dr; obs_rv = rv; obs_flt = flt; obs_busy = busy;
      mr = 1'b0; mw = 1'b0;
   endtask

   task automatic test_reset();
      int cnt;
      rst = 1'b1;
      ref_ready = 1'b0;
      clear_ref();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (dr !== 32'd0) begin errors++; $display("FAIL reset_dataread got %h exp %h", dr, 32'd0); end
      checks++; if (rv !== 1'b0) begin errors++; $display("FAIL reset_readvalid got %b exp 0", rv); end
      checks++; if (flt !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", flt); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_initbusy got %b exp 1", busy); end
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 1000) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      checks++; if (cnt !== D) begin errors++; $display("FAIL sweep_length got %0d exp %0d", cnt, D); end
      ref_ready = 1'b1;
      step(1'b1, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
      checks++; if (obs_rv !== 1'b1 || obs_dr !== 32'd0) begin errors++; $display("FAIL lw_0_after_init got rv=%b %h exp rv=1 00000000", obs_rv, obs_dr); end
      step(1'b1, 1'b0, 32'h3FC, 2'd2, 1'b0, 32'h0);
      checks++; if (obs_rv !== 1'b1 || obs_dr !== 32'd0) begin errors++; $display("FAIL lw_3fc_after_init got rv=%b %h exp rv=1 00000000", obs_rv, obs_dr); end
      step(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
      checks++; if (obs_rv !== 1'b0) begin errors++; $display("FAIL readvalid_pulse got %b exp 0", obs_rv); end
   endtask

   task automatic test_store_lanes();
      step(1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'h11223344);
      step(1'b0, 1'b1, 32'h11, 2'd0, 1'b1, 32'hFFFFFFAA);
      step(1'b0, 1'b1, 32'h12, 2'd1, 1'b0, 32'h1234BEEF);
      step(1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      checks++; if (obs_dr !== 32'hBEEFAA44 || obs_rv !== 1'b1) begin errors++; $display("FAIL store_lanes got rv=%b %h exp rv=1 beefaa44", obs_rv, obs_dr); end
   endtask

   task automatic test_load_ext();
      logic [31:0] ta [4] = '{32'h11, 32'h11, 32'h12, 32'h12};
      logic [1:0]  ts [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
      logic        tg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] te [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFFBEEF, 32'h0000BEEF};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, ta[i], ts[i], tg[i], 32'h0);
         checks++; if (obs_dr !== te[i] || obs_rv !== 1'b1) begin errors++; $display("FAIL load_ext_%0d got rv=%b %h exp rv=1 %h", i, obs_rv, obs_dr, te[i]); end
      end
   endtask

   task automatic test_faults();
      step(1'b0, 1'b1, 32'h20, 2'd2, 1'b0, 32'h01020304);
      checks++; if (obs_flt !== 1'b0) begin errors++; $display("FAIL legal_sw_fault got %b exp 0", obs_flt); end
      step(1'b0, 1'b1, 32'h22, 2'd2, 1'b0, 32'hDEADBEEF);
      checks++; if (obs_flt !== 1'b1) begin errors++; $display("FAIL misaligned_sw_fault got %b exp 1", obs_flt); end
      step(1'b1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
      checks++; if (obs_dr !== 32'h01020304 || obs_flt !== 1'b0) begin errors++; $display("FAIL sw_not_written got %h flt=%b exp 01020304 flt=0", obs_dr, obs_flt); end
      step(1'b1, 1'b0, 32'h21, 2'd1, 1'b0, 32'h0);
      checks++; if (obs_flt !== 1'b1 || obs_rv !== 1'b0) begin errors++; $display("FAIL misaligned_lh got flt=%b rv=%b exp flt=1 rv=0", obs_flt, obs_rv); end
      step(1'b1, 1'b0, 32'h400, 2'd2, 1'b0, 32'h0);
      checks++; if (obs_flt !== 1'b1 || obs_rv !== 1'b0) begin errors++; $display("FAIL out_of_range_lw got flt=%b rv=%b exp flt=1 rv=0", obs_flt, obs_rv); end
      checks++; if (obs_dr !== 32'h01020304) begin errors++; $display("FAIL dataread_hold got %h exp 01020304", obs_dr); end
      step(1'b1, 1'b0, 32'h0, 2'd3, 1'b0, 32'h0);
      checks++; if (obs_flt !== 1'b1 || obs_rv !== 1'b0) begin errors++; $display("FAIL reserved_size got flt=%b rv=%b exp flt=1 rv=0", obs_flt, obs_rv); end
      step(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
      checks++; if (obs_flt !== 1'b0) begin errors++; $display("FAIL fault_pulse got %b exp 0", obs_flt); end
   endtask

   task automatic test_rw_same();
      step(1'b0, 1'b1, 32'h30, 2'd2, 1'b0, 32'h5);
      step(1'b1, 1'b1, 32'h30, 2'd2, 1'b0, 32'h9);
      checks++; if (obs_dr !== 32'h5 || obs_rv !== 1'b1 || obs_flt !== 1'b0) begin errors++; $display("FAIL read_first got %h rv=%b flt=%b exp 00000005 rv=1 flt=0", obs_dr, obs_rv, obs_flt); end
      step(1'b1, 1'b0, 32'h30, 2'd2, 1'b0, 32'h0);
      checks++; if (obs_dr !== 32'h9) begin errors++; $display("FAIL write_after_rw got %h exp 00000009", obs_dr); end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [1:0]  s;
      int          k;
      for (int it = 0; it < 500; it++) begin
         s = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) s = 2'd3;
         else if (s == 2'd3) s = 2'd2;
         if ($urandom_range(0, 9) == 0) a = 32'(BYTES) + $urandom_range(0, 5000);
         else a = $urandom_range(0, 127);
         if ($urandom_range(0, 4) != 0 && s != 2'd3) a = a & ~((32'd1 << s) - 32'd1);
         k = $urandom_range(0, 3);
         step(k[1], k[0], a, s, 1'($urandom_range(0, 1)), $urandom);
         checks++; if (obs_rv !== e_rv) begin errors++; $display("FAIL rand_rv it=%0d got %b exp %b", it, obs_rv, e_rv); end
         checks++; if (obs_flt !== e_flt) begin errors++; $display("FAIL rand_fault it=%0d got %b exp %b", it, obs_flt, e_flt); end
         checks++; if (obs_dr !== ref_dr) begin errors++; $display("FAIL rand_data it=%0d got %h exp %h", it, obs_dr, ref_dr); end
      end
   endtask

   task automatic test_init_reject();
      int cnt;
      @(negedge clk);
      rst = 1'b1;
      ref_ready = 1'b0;
      clear_ref();
      @(negedge clk);
      rst = 1'b0;
      repeat (9) step(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h4, 2'd2, 1'b0, 32'h7);
      checks++; if (obs_flt !== e_flt || obs_flt !== 1'b1 || obs_busy !== 1'b1) begin errors++; $display("FAIL sw_during_init got flt=%b busy=%b exp flt=1 busy=1", obs_flt, obs_busy); end
      repeat (89) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midsweep_reset_busy got %b exp 1", busy); end
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 1000) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      checks++; if (cnt !== D) begin errors++; $display("FAIL resweep_length got %0d exp %0d", cnt, D); end
      ref_ready = 1'b1;
      step(1'b1, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0);
      checks++; if (obs_dr !== 32'd0 || obs_rv !== 1'b1) begin errors++; $display("FAIL word4_after_init got rv=%b %h exp rv=1 00000000", obs_rv, obs_dr); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mr = 1'b0; mw = 1'b0; addr = 32'h0; wd = 32'h0; sz = 2'd0; sg = 1'b0;
      test_reset();
      test_store_lanes();
      test_load_ext();
      test_faults();
      test_rw_same();
      test_random();
      test_init_reject();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
